// File: rtl/hash_job_controller_if.sv
// Bundles host stream, result, hasher handshake and memory port of the job controller.
// master = controller side, slave = host/hasher/memory side.
// Widths are fixed by the memory map (16-bit address, 32-bit data, 4-bit nonce index).
`timescale 1ns/1ps
interface hash_job_controller_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] target;
  logic        hash_start;
  logic        hash_done;
  logic        mem_owner;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        result_valid;
  logic        result_ready;
  logic        result_found;
  logic        result_error;
  logic [3:0]  result_nonce;
  logic [31:0] result_hash;

  modport master (
    input  in_valid, in_data, target, hash_done, mem_read_data, result_ready,
    output in_ready, hash_start, mem_owner, mem_we, mem_addr, mem_write_data,
           result_valid, result_found, result_error, result_nonce, result_hash
  );

  modport slave (
    output in_valid, in_data, target, hash_done, mem_read_data, result_ready,
    input  in_ready, hash_start, mem_owner, mem_we, mem_addr, mem_write_data,
           result_valid, result_found, result_error, result_nonce, result_hash
  );
endinterface

// File: rtl/hash_job_controller.sv
// Host-side sequencer: loads a header into memory, runs bitcoin_hash, scans its results for the minimum.
// Latency: header word written on its accept edge; start 1 cycle after last word; result 18 cycles after done rises.
// Backpressure: in_ready low from START until the result is taken; the result is held until result_ready.
`timescale 1ns/1ps
module hash_job_controller #(
  parameter int          NUM_WORDS  = 19,
  parameter int          NUM_NONCES = 16,
  parameter logic [15:0] MSG_ADDR   = 16'h0000,
  parameter logic [15:0] OUT_ADDR   = 16'h0100,
  parameter int          TIMEOUT    = 4096
) (
  input logic                   clk,
  input logic                   reset_n,
  hash_job_controller_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD, REPORT} state_t;

  state_t        state, state_nxt;
  logic [4:0]    wcnt, wcnt_nxt;          // header words accepted so far
  logic [4:0]    rcnt, rcnt_nxt;          // unload cycle index, 0..NUM_NONCES
  logic [TW-1:0] tcnt, tcnt_nxt;          // cycles elapsed since the start pulse
  logic [31:0]   tgt, tgt_nxt;
  logic [31:0]   min_hash, min_hash_nxt;
  logic [3:0]    min_idx, min_idx_nxt;
  logic          err, err_nxt;

  // State and job registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      tcnt     <= '0;
      tgt      <= '0;
      min_hash <= '1;
      min_idx  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      rcnt     <= rcnt_nxt;
      tcnt     <= tcnt_nxt;
      tgt      <= tgt_nxt;
      min_hash <= min_hash_nxt;
      min_idx  <= min_idx_nxt;
      err      <= err_nxt;
    end
  end

  // Next-state and output decode; every output is a function of state and the current inputs.
  always_comb begin
    state_nxt          = state;
    wcnt_nxt           = wcnt;
    rcnt_nxt           = rcnt;
    tcnt_nxt           = tcnt;
    tgt_nxt            = tgt;
    min_hash_nxt       = min_hash;
    min_idx_nxt        = min_idx;
    err_nxt            = err;
    bus.in_ready       = 1'b0;
    bus.hash_start     = 1'b0;
    bus.mem_owner      = 1'b1;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.result_valid   = 1'b0;
    bus.result_found   = 1'b0;
    bus.result_error   = 1'b0;
    bus.result_nonce   = '0;
    bus.result_hash    = '0;

    unique case (state)
      IDLE, LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // The write lands on the same edge that accepts the word.
          bus.mem_we         = 1'b1;
          bus.mem_addr       = MSG_ADDR + 16'(wcnt);
          bus.mem_write_data = bus.in_data;
          wcnt_nxt           = wcnt + 5'd1;
          if (state == IDLE) tgt_nxt = bus.target;
          state_nxt = (wcnt == 5'(NUM_WORDS - 1)) ? START : LOAD;
        end
      end
      START: begin
        bus.hash_start = 1'b1;
        bus.mem_owner  = 1'b0;
        // START itself counts as the first elapsed cycle, so a timeout
        // lands exactly TIMEOUT cycles after the start pulse.
        tcnt_nxt       = TW'(1);
        wcnt_nxt       = '0;
        rcnt_nxt       = '0;
        min_hash_nxt   = '1;
        min_idx_nxt    = '0;
        err_nxt        = 1'b0;
        state_nxt      = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        bus.mem_owner = 1'b0;
        tcnt_nxt      = tcnt + TW'(1);
        // done is high while the hasher idles, so it must fall before a rise means completion.
        if (state == WAIT_BUSY && !bus.hash_done) begin
          state_nxt = WAIT_DONE;
        end else if (state == WAIT_DONE && bus.hash_done) begin
          state_nxt = UNLOAD;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_nxt = REPORT;
          err_nxt   = 1'b1;
        end
      end
      UNLOAD: begin
        if (rcnt < 5'(NUM_NONCES)) bus.mem_addr = OUT_ADDR + 16'(rcnt);
        // Read data trails its address by one cycle; strict compare keeps the lowest index on ties.
        if (rcnt != 5'd0 && bus.mem_read_data < min_hash) begin
          min_hash_nxt = bus.mem_read_data;
          min_idx_nxt  = 4'(rcnt - 5'd1);
        end
        rcnt_nxt = rcnt + 5'd1;
        if (rcnt == 5'(NUM_NONCES)) state_nxt = REPORT;
      end
      REPORT: begin
        bus.result_valid = 1'b1;
        bus.result_error = err;
        bus.result_found = !err && (min_hash < tgt);
        bus.result_nonce = min_idx;
        bus.result_hash  = min_hash;
        if (bus.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hash_job_controller.sv
// Bench for hash_job_controller: memory + mux model, behavioural hasher, table of jobs.
// Each job checks header writes, start timing, unload latency and the reported minimum.
// Hand sequences cover reset values, reset mid-unload and a discarded partial header.
`timescale 1ns/1ps
module tb_hash_job_controller;
  typedef struct {
    logic [31:0] tgt;
    int          pat;     // 0 descending, 1 tie at 3/9, 2 all max, 3 hasher hangs, 4 zero at 7
    bit          gaps;
    int          bdly;    // cycles done stays high after start
    bit          b2b;     // result_ready pre-asserted, next header follows at once
    logic [3:0]  enonce;
    logic [31:0] ehash;
    bit          efound;
    bit          eerr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  // Cycle index used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  hash_job_controller_if bus();

  hash_job_controller #(
    .NUM_WORDS(19), .NUM_NONCES(16), .MSG_ADDR(16'h0000), .OUT_ADDR(16'h0100), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Single-port synchronous memory behind the owner mux.
  logic [31:0] mem [512];
  logic [31:0] rd_q = '0;
  logic        h_we = 1'b0;
  logic [15:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  always @(posedge clk) begin
    if (bus.mem_owner) begin
      if (bus.mem_we) mem[bus.mem_addr[8:0]] <= bus.mem_write_data;
      rd_q <= mem[bus.mem_addr[8:0]];
    end else begin
      if (h_we) mem[h_addr[8:0]] <= h_wdata;
      rd_q <= mem[h_addr[8:0]];
    end
  end
  assign bus.mem_read_data = rd_q;

  // Hasher model: done falls after bdly+1 cycles, 16 result words are written, done rises.
  logic [31:0] hashes [16];
  bit          hang = 1'b0;
  int          bdly = 0;
  int          done_cyc = 0;
  initial begin
    bus.hash_done = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.hash_start && !hang) begin
        repeat (bdly + 1) @(posedge clk);
        #1 bus.hash_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int j = 0; j < 16; j++) begin
          h_we = 1'b1; h_addr = 16'h0100 + 16'(j); h_wdata = hashes[j];
          @(posedge clk); #1;
        end
        h_we = 1'b0;
        bus.hash_done = 1'b1;
        done_cyc = cyc;
      end
    end
  end

  // Monitor: logs header writes and start pulses.
  logic [15:0] wr_addr [1024];
  logic [31:0] wr_data [1024];
  int          wr_cyc  [1024];
  int          wr_n = 0;
  int          start_n = 0;
  int          start_cyc = 0;
  logic        owner_at_start = 1'b1;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        wr_addr[wr_n[9:0]] <= bus.mem_addr;
        wr_data[wr_n[9:0]] <= bus.mem_write_data;
        wr_cyc[wr_n[9:0]]  <= cyc;
        wr_n <= wr_n + 1;
      end
      if (bus.hash_start) begin
        start_n <= start_n + 1;
        start_cyc <= cyc;
        owner_at_start <= bus.mem_owner;
      end
    end
  end

  int prev_rep = 0;
  bit prev_b2b = 1'b0;
  vec_t vecs [8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int job, input int i);
    return 32'h1000_0000 + (32'(job) << 16) + 32'(i);
  endfunction

  task automatic set_hashes(input int pat);
    for (int j = 0; j < 16; j++) begin
      case (pat)
        0:       hashes[j] = 32'hF000_0000 - (32'(j) << 16);
        1:       hashes[j] = (j == 3 || j == 9) ? 32'h0000_0005 : 32'h1000_0000 + 32'(j);
        2:       hashes[j] = 32'hFFFF_FFFF;
        4:       hashes[j] = (j == 7) ? 32'h0 : 32'h1234_0000 + 32'(j);
        default: hashes[j] = 32'hDEAD_0000 + 32'(j);
      endcase
    end
  endtask

  task automatic check_reset(input string tag);
    check32({tag, "_in_ready"},     32'(bus.in_ready), 32'd1);
    check32({tag, "_hash_start"},   32'(bus.hash_start), 32'd0);
    check32({tag, "_mem_owner"},    32'(bus.mem_owner), 32'd1);
    check32({tag, "_mem_we"},       32'(bus.mem_we), 32'd0);
    check32({tag, "_mem_addr"},     32'(bus.mem_addr), 32'd0);
    check32({tag, "_mem_wdata"},    bus.mem_write_data, 32'd0);
    check32({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check32({tag, "_result_found"}, 32'(bus.result_found), 32'd0);
    check32({tag, "_result_error"}, 32'(bus.result_error), 32'd0);
    check32({tag, "_result_nonce"}, 32'(bus.result_nonce), 32'd0);
    check32({tag, "_result_hash"},  bus.result_hash, 32'd0);
  endtask

  task automatic load_header(input int job, input bit gaps, input int nwords);
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      if (gaps && i > 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = hdr(job, i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int job);
    int base_w, base_s, nw, rep;
    bit got;
    logic [9:0] idx;
    set_hashes(v.pat);
    hang = (v.pat == 3);
    bdly = v.bdly;
    bus.target = v.tgt;
    base_w = wr_n;
    base_s = start_n;
    load_header(job, v.gaps, 19);
    if (v.b2b) bus.result_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = bus.result_valid;
    end
    check32($sformatf("job%0d_result_valid_seen", job), 32'(got), 32'd1);
    if (!got) return;
    rep = cyc;
    check32($sformatf("job%0d_nonce", job), 32'(bus.result_nonce), 32'(v.enonce));
    check32($sformatf("job%0d_hash", job), bus.result_hash, v.ehash);
    check32($sformatf("job%0d_found", job), 32'(bus.result_found), 32'(v.efound));
    check32($sformatf("job%0d_error", job), 32'(bus.result_error), 32'(v.eerr));
    check32($sformatf("job%0d_owner_report", job), 32'(bus.mem_owner), 32'd1);
    check32($sformatf("job%0d_in_ready_report", job), 32'(bus.in_ready), 32'd0);
    if (v.eerr) check32($sformatf("job%0d_start_to_report", job), 32'(rep - start_cyc), 32'd64);
    else        check32($sformatf("job%0d_done_to_valid", job), 32'(rep - done_cyc), 32'd18);
    check32($sformatf("job%0d_start_pulses", job), 32'(start_n - base_s), 32'd1);
    check32($sformatf("job%0d_owner_at_start", job), 32'(owner_at_start), 32'd0);
    nw = wr_n - base_w;
    check32($sformatf("job%0d_write_count", job), 32'(nw), 32'd19);
    for (int i = 0; i < 19 && i < nw; i++) begin
      idx = 10'(base_w + i);
      check32($sformatf("job%0d_wr%0d_addr", job, i), 32'(wr_addr[idx]), 32'(i));
      check32($sformatf("job%0d_wr%0d_data", job, i), wr_data[idx], hdr(job, i));
    end
    if (nw >= 19) begin
      idx = 10'(base_w + 18);
      check32($sformatf("job%0d_load_to_start", job), 32'(start_cyc - wr_cyc[idx]), 32'd1);
    end
    if (prev_b2b && nw > 0) begin
      idx = 10'(base_w);
      check32($sformatf("job%0d_b2b_first_accept", job), 32'(wr_cyc[idx] - prev_rep), 32'd1);
    end
    prev_rep = rep;
    prev_b2b = v.b2b;
    if (!v.b2b) begin
      repeat (2) @(negedge clk);
      check32($sformatf("job%0d_valid_held", job), 32'(bus.result_valid), 32'd1);
      check32($sformatf("job%0d_hash_held", job), bus.result_hash, v.ehash);
      @(posedge clk); #1 bus.result_ready = 1'b1;
      @(posedge clk); #1 bus.result_ready = 1'b0;
      @(negedge clk);
      check32($sformatf("job%0d_valid_after_ready", job), 32'(bus.result_valid), 32'd0);
      check32($sformatf("job%0d_in_ready_idle", job), 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit seen_low, seen_rise;
    vecs[0] = '{32'h8000_0000, 0, 1'b0, 0, 1'b0, 4'd15, 32'hEFF1_0000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 0, 1'b1, 2, 1'b1, 4'd15, 32'hEFF1_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 1, 1'b0, 0, 1'b0, 4'd3,  32'h0000_0005, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0006, 1, 1'b1, 3, 1'b0, 4'd3,  32'h0000_0005, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 2, 1'b0, 0, 1'b0, 4'd0,  32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0001, 4, 1'b0, 4, 1'b0, 4'd7,  32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 3, 1'b0, 0, 1'b0, 4'd0,  32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0000, 0, 1'b1, 1, 1'b0, 4'd15, 32'hEFF1_0000, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.target = '0;
    bus.result_ready = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clk) reset_n = 1'b1;

    for (int n = 0; n < 8; n++) run_job(vecs[n], n);

    // Reset on the 5th unload read cycle.
    set_hashes(0);
    hang = 1'b0;
    bdly = 0;
    bus.target = 32'h8000_0000;
    load_header(8, 1'b0, 19);
    seen_low = 1'b0;
    seen_rise = 1'b0;
    for (int k = 0; k < 200 && !seen_rise; k++) begin
      @(negedge clk);
      if (!bus.hash_done) seen_low = 1'b1;
      else if (seen_low) seen_rise = 1'b1;
    end
    check32("midunload_done_rise_seen", 32'(seen_rise), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    check32("midunload_5th_read_addr", 32'(bus.mem_addr), 32'h0000_0104);
    reset_n = 1'b0;
    #1;
    check_reset("midunload");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Partial header abandoned by reset; the next job must start again at word 0.
    bus.target = 32'h8000_0000;
    load_header(9, 1'b0, 5);
    #1 reset_n = 1'b0;
    #1;
    check32("partial_reset_mem_we", 32'(bus.mem_we), 32'd0);
    check32("partial_reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk) reset_n = 1'b1;
    prev_b2b = 1'b0;
    run_job(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
